// File: rtl/sie_packet_sequencer.sv
// sie_packet_sequencer: feeds SYNC, PID and packet bytes to the SIE parallel load port (clock/reset, request in, load_SIE/parallel_ip/status out)
module sie_packet_sequencer #(
  parameter int BYTE_PERIOD = 8,
  parameter int MAX_DATA = 8,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       pkt_type,
  input  logic [3:0]       pid,
  input  logic [6:0]       addr,
  input  logic [3:0]       endp,
  input  logic [LEN_W-1:0] data_len,
  input  logic [7:0]       data_in,
  input  logic             data_avail,
  output logic             data_rd,
  output logic             load_SIE,
  output logic [7:0]       parallel_ip,
  output logic             busy,
  output logic             done,
  output logic             err_req,
  output logic             err_underrun
);
  localparam int CW = BYTE_PERIOD > 1 ? $clog2(BYTE_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTE_PERIOD - 1);
  typedef enum logic [2:0] {IDLE, SYNC, PID, TOK1, TOK2, DATA, CRC_LO, CRC_HI} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] typ;
  logic [3:0] pid_r, endp_r;
  logic [6:0] addr_r;
  logic [LEN_W-1:0] rem;
  logic [7:0] hold, byte_now;
  logic slot_end, last_slot, accepting, bad, ok, pay;
  always_comb begin
    slot_end = state != IDLE && cnt == LAST;
    last_slot = state == TOK2 || state == CRC_HI || (state == PID && typ == 2'b10);
    accepting = state == IDLE || (last_slot && slot_end);
    bad = pkt_type == 2'b11 || (pkt_type == 2'b01 && data_len > LEN_W'(MAX_DATA));
    ok = start && accepting && !bad;
    load_SIE = state != IDLE && cnt == '0;
    pay = load_SIE && state == DATA;
    byte_now = state == SYNC ? 8'h80 :
               state == PID  ? {~pid_r, pid_r} :
               state == TOK1 ? {endp_r[0], addr_r} :
               state == TOK2 ? {5'b0, endp_r[3:1]} :
               state == DATA && data_avail ? data_in : 8'h00;
    parallel_ip = load_SIE ? byte_now : hold;
    data_rd = pay && data_avail;
    busy = state != IDLE;
    done = last_slot && slot_end;
    err_req = start && accepting && bad;
    state_n = state;
    if (state == IDLE || (last_slot && slot_end))
      state_n = ok ? SYNC : IDLE;
    else if (slot_end)
      case (state)
        SYNC:    state_n = PID;
        PID:     state_n = typ == 2'b00 ? TOK1 : rem != '0 ? DATA : CRC_LO;
        TOK1:    state_n = TOK2;
        DATA:    state_n = rem == LEN_W'(1) ? CRC_LO : DATA;
        CRC_LO:  state_n = CRC_HI;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hold <= 8'h00;
      err_underrun <= 1'b0;
      typ <= 2'b00;
      pid_r <= 4'h0;
      addr_r <= 7'h00;
      endp_r <= 4'h0;
      rem <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || slot_end) ? '0 : cnt + 1'b1;
      hold <= parallel_ip;
      err_underrun <= ok ? 1'b0 : (pay && !data_avail) ? 1'b1 : err_underrun;
      if (ok) begin
        typ <= pkt_type;
        pid_r <= pid;
        addr_r <= addr;
        endp_r <= endp;
        rem <= data_len;
      end else if (state == DATA && slot_end)
        rem <= rem - 1'b1;
    end
  end
endmodule

// File: tb/tb_sie_packet_sequencer.sv
// tb_sie_packet_sequencer: directed self-checking bench for sie_packet_sequencer
module tb_sie_packet_sequencer;
  logic clock = 0, reset, start, data_avail;
  logic [1:0] pkt_type;
  logic [3:0] pid, endp, data_len;
  logic [6:0] addr;
  logic [7:0] data_in, parallel_ip;
  logic data_rd, load_SIE, busy, done, err_req, err_underrun;
  int cyc = 0, checks = 0, errors = 0, t0, t1;
  int lb[$], lc[$], rc[$], dc[$], ec[$];
  int eb[$], elc[$], erc[$], edc[$], eec[$];
  sie_packet_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .pkt_type(pkt_type), .pid(pid),
    .addr(addr), .endp(endp), .data_len(data_len), .data_in(data_in),
    .data_avail(data_avail), .data_rd(data_rd), .load_SIE(load_SIE),
    .parallel_ip(parallel_ip), .busy(busy), .done(done), .err_req(err_req),
    .err_underrun(err_underrun)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (load_SIE === 1'b1) begin
      lb.push_back(int'(parallel_ip));
      lc.push_back(cyc);
    end
    if (data_rd === 1'b1) rc.push_back(cyc);
    if (done === 1'b1) dc.push_back(cyc);
    if (err_req === 1'b1) ec.push_back(cyc);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cmpq(input string tag, input int g[$], input int e[$]);
    chk({tag, " count"}, g.size(), e.size());
    for (int i = 0; i < g.size() && i < e.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), g[i], e[i]);
  endtask
  task automatic clr();
    lb.delete(); lc.delete(); rc.delete(); dc.delete(); ec.delete();
    eb.delete(); elc.delete(); erc.delete(); edc.delete(); eec.delete();
  endtask
  task automatic check_log(input string tag);
    cmpq({tag, " byte"}, lb, eb);
    cmpq({tag, " load_cyc"}, lc, elc);
    cmpq({tag, " rd_cyc"}, rc, erc);
    cmpq({tag, " done_cyc"}, dc, edc);
    cmpq({tag, " err_req_cyc"}, ec, eec);
    clr();
  endtask
  task automatic exp_pkt(input int t, input int b[$]);
    foreach (b[k]) begin
      eb.push_back(b[k]);
      elc.push_back(t + 1 + 8 * k);
    end
    edc.push_back(t + 8 * b.size());
  endtask
  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic req(input logic [1:0] t, input logic [3:0] p, input logic [6:0] a,
                     input logic [3:0] e, input logic [3:0] l, output int ts);
    pkt_type = t; pid = p; addr = a; endp = e; data_len = l; start = 1;
    ts = cyc;
    @(posedge clock);
    #1;
    start = 0; pkt_type = ~t; pid = ~p; addr = ~a; endp = ~e; data_len = 4'hf;
  endtask
  task automatic chk_idle(input string tag);
    @(negedge clock);
    chk({tag, " load_SIE"}, load_SIE, 0);
    chk({tag, " parallel_ip"}, parallel_ip, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " data_rd"}, data_rd, 0);
    chk({tag, " err_req"}, err_req, 0);
    chk({tag, " err_underrun"}, err_underrun, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    reset = 1; start = 0; pkt_type = 0; pid = 0; addr = 0; endp = 0; data_len = 0;
    data_in = 8'h62; data_avail = 1;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    chk_idle("reset");
    clr();
    req(2'b00, 4'b1001, 7'b0010110, 4'b0110, 0, t0);
    to_cyc(t0 + 33);
    @(negedge clock);
    chk("token busy_end", busy, 0);
    exp_pkt(t0, '{'h80, 'h69, 'h16, 'h03});
    check_log("token");
    req(2'b01, 4'b0011, 0, 0, 1, t0);
    to_cyc(t0 + 41);
    @(negedge clock);
    chk("data1 busy_end", busy, 0);
    exp_pkt(t0, '{'h80, 'hC3, 'h62, 'h00, 'h00});
    erc.push_back(t0 + 17);
    check_log("data1");
    req(2'b01, 4'b0011, 0, 0, 0, t0);
    to_cyc(t0 + 33);
    @(negedge clock);
    chk("data0 busy_end", busy, 0);
    exp_pkt(t0, '{'h80, 'hC3, 'h00, 'h00});
    check_log("data0");
    req(2'b10, 4'b0010, 0, 0, 0, t0);
    to_cyc(t0 + 16);
    req(2'b00, 4'b1001, 7'b0010110, 4'b0110, 0, t1);
    @(negedge clock);
    chk("gapless busy", busy, 1);
    to_cyc(t1 + 33);
    @(negedge clock);
    chk("gapless busy_end", busy, 0);
    exp_pkt(t0, '{'h80, 'hD2});
    exp_pkt(t1, '{'h80, 'h69, 'h16, 'h03});
    check_log("gapless");
    req(2'b01, 4'b0011, 0, 0, 3, t0);
    to_cyc(t0 + 20);
    data_avail = 0;
    @(negedge clock);
    chk("underrun pre", err_underrun, 0);
    to_cyc(t0 + 27);
    data_avail = 1;
    data_in = 8'h5A;
    @(negedge clock);
    chk("underrun set", err_underrun, 1);
    to_cyc(t0 + 57);
    @(negedge clock);
    chk("underrun busy_end", busy, 0);
    chk("underrun sticky", err_underrun, 1);
    exp_pkt(t0, '{'h80, 'hC3, 'h62, 'h00, 'h5A, 'h00, 'h00});
    erc.push_back(t0 + 17);
    erc.push_back(t0 + 33);
    check_log("underrun");
    req(2'b10, 4'b0010, 0, 0, 0, t1);
    @(negedge clock);
    chk("underrun clear", err_underrun, 0);
    to_cyc(t1 + 17);
    exp_pkt(t1, '{'h80, 'hD2});
    check_log("ack");
    req(2'b11, 4'b0010, 0, 0, 0, t0);
    eec.push_back(t0);
    @(negedge clock);
    chk("rej11 err_req_len", err_req, 0);
    req(2'b01, 4'b0011, 0, 0, 9, t0);
    eec.push_back(t0);
    to_cyc(t0 + 20);
    @(negedge clock);
    chk("reject busy", busy, 0);
    check_log("reject");
    req(2'b10, 4'b0010, 0, 0, 0, t0);
    to_cyc(t0 + 16);
    req(2'b11, 4'b0000, 0, 0, 0, t1);
    to_cyc(t0 + 30);
    @(negedge clock);
    chk("b2b reject busy", busy, 0);
    exp_pkt(t0, '{'h80, 'hD2});
    eec.push_back(t0 + 16);
    check_log("b2b_reject");
    req(2'b01, 4'b0011, 0, 0, 2, t0);
    to_cyc(t0 + 12);
    reset = 1;
    to_cyc(t0 + 13);
    reset = 0;
    chk_idle("midreset");
    eb.push_back('h80); eb.push_back('hC3);
    elc.push_back(t0 + 1); elc.push_back(t0 + 9);
    check_log("midreset");
    req(2'b00, 4'b1001, 7'b0010110, 4'b0110, 0, t1);
    to_cyc(t1 + 33);
    @(negedge clock);
    chk("postreset busy_end", busy, 0);
    exp_pkt(t1, '{'h80, 'h69, 'h16, 'h03});
    check_log("postreset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
